// File: rtl/gaussian_elim_engine.sv
// Gaussian-elimination row-update engine: streams A[r][col] -= c[p]*A[p][col]
// over every pivot at one element per cycle through a two-stage datapath.
module gaussian_elim_engine #(
    parameter int N         = 16,
    parameter int DATA_W    = 32,
    parameter int AW        = $clog2(N * N),
    parameter int CW        = (N > 2) ? $clog2(N) : 1,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              c_rd_en,
    output logic [CW-1:0]     c_rd_addr,
    input  logic [DATA_W-1:0] c_rd_data,
    output logic              a_rd_en,
    output logic [AW-1:0]     a_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    output logic              b_rd_en,
    output logic [AW-1:0]     b_rd_addr,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic              st_en,
    output logic [AW-1:0]     st_addr,
    output logic [DATA_W-1:0] st_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_C = 3'd1,
        WAIT_C = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] PEN_IDX  = CW'(N - 2);
    localparam logic [AW-1:0] N_AW     = AW'(N);
    localparam logic [AW-1:0] LAST_AW  = AW'(N - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [CW-1:0]       p_r;
    logic [CW-1:0]       r_r;
    logic [CW-1:0]       col_r;
    logic [DATA_W-1:0]   c_r;
    logic [AW-1:0]       a_addr_r;
    logic [AW-1:0]       b_addr_r;
    logic                drain_cnt_r;
    logic                issue_r;
    logic                busy_r;
    logic                done_r;
    logic                c_rd_en_r;
    logic [CW-1:0]       c_rd_addr_r;
    logic                v1_r;
    logic [AW-1:0]       addr1_r;
    logic                v2_r;
    logic [AW-1:0]       addr2_r;
    logic [DATA_W-1:0]   a_q_r;
    logic [DATA_W-1:0]   prod_r;

    logic                skip_pivot_s;
    logic                last_elem_s;
    logic                row_end_s;
    logic [AW-1:0]       pivot_diag_s;

    assign skip_pivot_s = (SKIP_ZERO == 1'b1) && (c_rd_data == {DATA_W{1'b0}});
    assign row_end_s    = (col_r == LAST_IDX);
    assign last_elem_s  = (r_r == LAST_IDX) && row_end_s;
    assign pivot_diag_s = AW'(p_r) * N_AW + AW'(p_r);

    // Next-state decode of the run sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = LOAD_C;
                else       state_next_s = IDLE;
            end
            LOAD_C: state_next_s = WAIT_C;
            WAIT_C: begin
                if (skip_pivot_s) state_next_s = DRAIN;
                else              state_next_s = STREAM;
            end
            STREAM: begin
                if (last_elem_s) state_next_s = DRAIN;
                else             state_next_s = STREAM;
            end
            DRAIN: begin
                if (drain_cnt_r) begin
                    if (p_r == PEN_IDX) state_next_s = DONE;
                    else                state_next_s = LOAD_C;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, loop counters, c capture and registered read-port strobes/addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            p_r         <= {CW{1'b0}};
            r_r         <= {CW{1'b0}};
            col_r       <= {CW{1'b0}};
            c_r         <= {DATA_W{1'b0}};
            a_addr_r    <= {AW{1'b0}};
            b_addr_r    <= {AW{1'b0}};
            drain_cnt_r <= 1'b0;
            issue_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            c_rd_en_r   <= 1'b0;
            c_rd_addr_r <= {CW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            busy_r    <= (state_next_s == LOAD_C) || (state_next_s == WAIT_C) ||
                         (state_next_s == STREAM) || (state_next_s == DRAIN);
            done_r    <= (state_next_s == DONE);
            c_rd_en_r <= (state_next_s == LOAD_C);
            issue_r   <= (state_next_s == STREAM);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        p_r         <= {CW{1'b0}};
                        c_rd_addr_r <= {CW{1'b0}};
                    end else begin
                        p_r <= p_r;
                    end
                end
                WAIT_C: begin
                    c_r         <= c_rd_data;
                    r_r         <= p_r + 1'b1;
                    col_r       <= p_r;
                    b_addr_r    <= pivot_diag_s;
                    a_addr_r    <= pivot_diag_s + N_AW;
                    drain_cnt_r <= 1'b0;
                end
                STREAM: begin
                    // Row wrap jumps both addresses back to column p.
                    if (row_end_s) begin
                        col_r    <= p_r;
                        r_r      <= r_r + 1'b1;
                        a_addr_r <= a_addr_r + 1'b1 + AW'(p_r);
                        b_addr_r <= b_addr_r - LAST_AW + AW'(p_r);
                    end else begin
                        col_r    <= col_r + 1'b1;
                        a_addr_r <= a_addr_r + 1'b1;
                        b_addr_r <= b_addr_r + 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt_r <= ~drain_cnt_r;
                    if (drain_cnt_r && (p_r != PEN_IDX)) begin
                        p_r         <= p_r + 1'b1;
                        c_rd_addr_r <= p_r + 1'b1;
                    end else begin
                        p_r <= p_r;
                    end
                end
                default: p_r <= p_r;
            endcase
        end
    end

    // Two-stage update pipeline: operand/product capture, then the store.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            addr1_r <= {AW{1'b0}};
            v2_r    <= 1'b0;
            addr2_r <= {AW{1'b0}};
            a_q_r   <= {DATA_W{1'b0}};
            prod_r  <= {DATA_W{1'b0}};
        end else begin
            v1_r    <= issue_r;
            addr1_r <= a_addr_r;
            v2_r    <= v1_r;
            addr2_r <= addr1_r;
            if (v1_r) begin
                a_q_r  <= a_rd_data;
                prod_r <= c_r * b_rd_data;
            end else begin
                a_q_r  <= a_q_r;
                prod_r <= prod_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign c_rd_en   = c_rd_en_r;
    assign c_rd_addr = c_rd_addr_r;
    assign a_rd_en   = issue_r;
    assign a_rd_addr = a_addr_r;
    assign b_rd_en   = issue_r;
    assign b_rd_addr = b_addr_r;
    assign st_en     = v2_r;
    assign st_addr   = addr2_r;
    assign st_data   = a_q_r - prod_r;

endmodule

// File: tb/tb_gaussian_elim_engine.sv
// Self-checking bench: two engines (N=4 with zero-pivot skip, N=2 without) against
// a loop-level elimination model, plus reset and start-handling checks.
module tb_gaussian_elim_engine;

    localparam int NA = 4;
    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    logic load_a, load_b, clr_a, clr_b;

    logic        busy_a, done_a, c_rd_en_a, a_rd_en_a, b_rd_en_a, st_en_a;
    logic [1:0]  c_rd_addr_a;
    logic [3:0]  a_rd_addr_a, b_rd_addr_a, st_addr_a;
    logic [31:0] c_rd_data_a = 32'd0, a_rd_data_a = 32'd0, b_rd_data_a = 32'd0, st_data_a;

    logic        busy_b, done_b, c_rd_en_b, a_rd_en_b, b_rd_en_b, st_en_b;
    logic [0:0]  c_rd_addr_b;
    logic [1:0]  a_rd_addr_b, b_rd_addr_b, st_addr_b;
    logic [31:0] c_rd_data_b = 32'd0, a_rd_data_b = 32'd0, b_rd_data_b = 32'd0, st_data_b;

    gaussian_elim_engine #(.N(NA), .DATA_W(32), .SKIP_ZERO(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .c_rd_en(c_rd_en_a), .c_rd_addr(c_rd_addr_a), .c_rd_data(c_rd_data_a),
        .a_rd_en(a_rd_en_a), .a_rd_addr(a_rd_addr_a), .a_rd_data(a_rd_data_a),
        .b_rd_en(b_rd_en_a), .b_rd_addr(b_rd_addr_a), .b_rd_data(b_rd_data_a),
        .st_en(st_en_a), .st_addr(st_addr_a), .st_data(st_data_a)
    );

    gaussian_elim_engine #(.N(NB), .DATA_W(32), .SKIP_ZERO(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .c_rd_en(c_rd_en_b), .c_rd_addr(c_rd_addr_b), .c_rd_data(c_rd_data_b),
        .a_rd_en(a_rd_en_b), .a_rd_addr(a_rd_addr_b), .a_rd_data(a_rd_data_b),
        .b_rd_en(b_rd_en_b), .b_rd_addr(b_rd_addr_b), .b_rd_data(b_rd_data_b),
        .st_en(st_en_b), .st_addr(st_addr_b), .st_data(st_data_b)
    );

    logic [31:0] init_a [16];
    logic [31:0] cm_a   [4];
    logic [31:0] mem_a  [16];
    logic [3:0]  log_addr_a [64];
    logic [31:0] log_data_a [64];
    int busy_n_a = 0, done_n_a = 0, log_n_a = 0, rd_n_a = 0;

    logic [31:0] init_b [4];
    logic [31:0] cm_b   [2];
    logic [31:0] mem_b  [4];
    logic [1:0]  log_addr_b [64];
    logic [31:0] log_data_b [64];
    int busy_n_b = 0, done_n_b = 0, log_n_b = 0, rd_n_b = 0;

    // Memory model and activity monitor for engine A.
    always @(posedge clk) begin
        if (c_rd_en_a) c_rd_data_a <= cm_a[c_rd_addr_a];
        if (a_rd_en_a) a_rd_data_a <= mem_a[a_rd_addr_a];
        if (b_rd_en_a) b_rd_data_a <= mem_a[b_rd_addr_a];
        if (load_a) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= init_a[i];
        end else if (st_en_a) begin
            mem_a[st_addr_a] <= st_data_a;
        end
        if (clr_a) begin
            busy_n_a <= 0; done_n_a <= 0; log_n_a <= 0; rd_n_a <= 0;
        end else begin
            if (busy_a) busy_n_a <= busy_n_a + 1;
            if (done_a) done_n_a <= done_n_a + 1;
            if (a_rd_en_a || b_rd_en_a) rd_n_a <= rd_n_a + 1;
            if (st_en_a) begin
                if (log_n_a < 64) begin
                    log_addr_a[log_n_a] <= st_addr_a;
                    log_data_a[log_n_a] <= st_data_a;
                end
                log_n_a <= log_n_a + 1;
            end
        end
    end

    // Memory model and activity monitor for engine B.
    always @(posedge clk) begin
        if (c_rd_en_b) c_rd_data_b <= cm_b[c_rd_addr_b];
        if (a_rd_en_b) a_rd_data_b <= mem_b[a_rd_addr_b];
        if (b_rd_en_b) b_rd_data_b <= mem_b[b_rd_addr_b];
        if (load_b) begin
            for (int i = 0; i < 4; i++) mem_b[i] <= init_b[i];
        end else if (st_en_b) begin
            mem_b[st_addr_b] <= st_data_b;
        end
        if (clr_b) begin
            busy_n_b <= 0; done_n_b <= 0; log_n_b <= 0; rd_n_b <= 0;
        end else begin
            if (busy_b) busy_n_b <= busy_n_b + 1;
            if (done_b) done_n_b <= done_n_b + 1;
            if (a_rd_en_b || b_rd_en_b) rd_n_b <= rd_n_b + 1;
            if (st_en_b) begin
                if (log_n_b < 64) begin
                    log_addr_b[log_n_b] <= st_addr_b;
                    log_data_b[log_n_b] <= st_data_b;
                end
                log_n_b <= log_n_b + 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] m_a [16];
    logic [31:0] m_c [4];
    int exp_addr [64];
    logic [31:0] exp_data [64];
    int exp_n, exp_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain triple loop of the elimination, with per-pivot busy cost.
    task automatic model(input int n, input bit skip);
        exp_n    = 0;
        exp_busy = 0;
        for (int p = 0; p <= n - 2; p++) begin
            exp_busy += 4;
            if (!(skip && m_c[p] == 32'd0)) begin
                for (int r = p + 1; r < n; r++) begin
                    for (int col = p; col < n; col++) begin
                        m_a[r*n+col] = m_a[r*n+col] - m_c[p] * m_a[p*n+col];
                        if (exp_n < 64) begin
                            exp_addr[exp_n] = r * n + col;
                            exp_data[exp_n] = m_a[r*n+col];
                        end
                        exp_n++;
                        exp_busy++;
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input string tag, input bit sel);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            seen = sel ? done_b : done_a;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_a(input string tag);
        for (int i = 0; i < 16; i++) m_a[i] = init_a[i];
        for (int i = 0; i < 4; i++)  m_c[i] = cm_a[i];
        model(NA, 1'b1);
        @(negedge clk); load_a = 1'b1; clr_a = 1'b1;
        @(negedge clk); load_a = 1'b0; clr_a = 1'b0; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done(tag, 1'b0);
        repeat (3) @(negedge clk);
        chk({tag, " busy_cycles"}, busy_n_a, exp_busy);
        chk({tag, " done_pulses"}, done_n_a, 32'd1);
        chk({tag, " stores"}, log_n_a, exp_n);
        chk({tag, " reads"}, rd_n_a, exp_n);
        for (int i = 0; i < exp_n && i < 64; i++) begin
            chk({tag, " st_addr"}, 32'(log_addr_a[i]), exp_addr[i]);
            chk({tag, " st_data"}, log_data_a[i], exp_data[i]);
        end
        for (int i = 0; i < 16; i++) chk({tag, " mem"}, mem_a[i], m_a[i]);
    endtask

    task automatic run_b(input string tag);
        for (int i = 0; i < 4; i++) m_a[i] = init_b[i];
        for (int i = 0; i < 2; i++) m_c[i] = cm_b[i];
        model(NB, 1'b0);
        @(negedge clk); load_b = 1'b1; clr_b = 1'b1;
        @(negedge clk); load_b = 1'b0; clr_b = 1'b0; start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        wait_done(tag, 1'b1);
        repeat (3) @(negedge clk);
        chk({tag, " busy_cycles"}, busy_n_b, exp_busy);
        chk({tag, " done_pulses"}, done_n_b, 32'd1);
        chk({tag, " stores"}, log_n_b, exp_n);
        chk({tag, " reads"}, rd_n_b, exp_n);
        for (int i = 0; i < exp_n && i < 64; i++) begin
            chk({tag, " st_addr"}, 32'(log_addr_b[i]), exp_addr[i]);
            chk({tag, " st_data"}, log_data_b[i], exp_data[i]);
        end
        for (int i = 0; i < 4; i++) chk({tag, " mem"}, mem_b[i], m_a[i]);
    endtask

    initial begin
        int busy1;
        int snap;
        bit seen;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        load_a = 1'b0; load_b = 1'b0; clr_a = 1'b1; clr_b = 1'b1;
        for (int i = 0; i < 16; i++) init_a[i] = 32'd0;
        for (int i = 0; i < 4; i++)  begin cm_a[i] = 32'd0; init_b[i] = 32'd0; end
        cm_b[0] = 32'd0; cm_b[1] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst busy_a", 32'(busy_a), 32'd0);
        chk("rst done_a", 32'(done_a), 32'd0);
        chk("rst c_rd_en_a", 32'(c_rd_en_a), 32'd0);
        chk("rst a_rd_en_a", 32'(a_rd_en_a), 32'd0);
        chk("rst b_rd_en_a", 32'(b_rd_en_a), 32'd0);
        chk("rst st_en_a", 32'(st_en_a), 32'd0);
        chk("rst st_data_a", st_data_a, 32'd0);
        chk("rst st_addr_a", 32'(st_addr_a), 32'd0);
        chk("rst busy_b", 32'(busy_b), 32'd0);
        chk("rst st_en_b", 32'(st_en_b), 32'd0);
        rst = 1'b0; clr_a = 1'b0; clr_b = 1'b0;

        // N=2 directed: A={{2,5},{7,11}}, c0=3.
        init_b[0] = 32'd2; init_b[1] = 32'd5; init_b[2] = 32'd7; init_b[3] = 32'd11;
        cm_b[0] = 32'd3; cm_b[1] = 32'd99;
        run_b("n2");
        chk("n2 busy_const", busy_n_b, 32'd6);
        chk("n2 st0_addr", 32'(log_addr_b[0]), 32'd2);
        chk("n2 st0_data", log_data_b[0], 32'd1);
        chk("n2 st1_addr", 32'(log_addr_b[1]), 32'd3);
        chk("n2 st1_data", log_data_b[1], 32'hFFFF_FFFC);

        // Multiplier truncation and subtraction wrap.
        init_b[0] = 32'd2; init_b[1] = 32'd2; init_b[2] = 32'd0; init_b[3] = 32'd0;
        cm_b[0] = 32'hFFFF_FFFF;
        run_b("wrap");
        chk("wrap st0_data", log_data_b[0], 32'd2);
        chk("wrap st1_data", log_data_b[1], 32'd2);

        // N=4 directed: A[i][j]=4i+j+1, c=1.
        for (int i = 0; i < 16; i++) init_a[i] = 32'(i + 1);
        for (int i = 0; i < 4; i++)  cm_a[i] = 32'd1;
        run_a("n4");
        chk("n4 busy_const", busy_n_a, 32'd32);
        chk("n4 stores_const", log_n_a, 32'd20);

        // Zero pivot skipped.
        for (int i = 0; i < 16; i++) init_a[i] = $urandom;
        cm_a[0] = 32'd0; cm_a[1] = 32'd1; cm_a[2] = 32'd1; cm_a[3] = 32'd1;
        run_a("skip");
        chk("skip busy_const", busy_n_a, 32'd20);
        chk("skip stores_const", log_n_a, 32'd8);
        chk("skip reads_const", rd_n_a, 32'd8);

        // Random matrices and factors, some factors zero.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) init_a[i] = $urandom;
            for (int i = 0; i < 4; i++)  cm_a[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            run_a("rand_a");
            for (int i = 0; i < 4; i++) init_b[i] = $urandom;
            for (int i = 0; i < 2; i++) cm_b[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            run_b("rand_b");
        end

        // Reset mid-stream, then a clean full run.
        for (int i = 0; i < 16; i++) init_a[i] = $urandom;
        for (int i = 0; i < 4; i++)  cm_a[i] = $urandom | 32'd1;
        @(negedge clk); load_a = 1'b1;
        @(negedge clk); load_a = 1'b0; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = a_rd_en_a;
        end
        chk("mid stream_reached", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid st_en", 32'(st_en_a), 32'd0);
        chk("mid busy", 32'(busy_a), 32'd0);
        chk("mid done", 32'(done_a), 32'd0);
        chk("mid a_rd_en", 32'(a_rd_en_a), 32'd0);
        rst = 1'b0;
        snap = log_n_a;
        repeat (5) @(negedge clk);
        chk("mid no_stores", log_n_a, snap);
        chk("mid stay_idle", 32'(busy_a), 32'd0);
        for (int i = 0; i < 16; i++) init_a[i] = $urandom;
        run_a("post_rst");

        // start held high across a run, plus a pulse while busy.
        for (int i = 0; i < 16; i++) init_a[i] = $urandom;
        for (int i = 0; i < 4; i++)  cm_a[i] = $urandom | 32'd1;
        for (int i = 0; i < 16; i++) m_a[i] = init_a[i];
        for (int i = 0; i < 4; i++)  m_c[i] = cm_a[i];
        model(NA, 1'b1);
        busy1 = exp_busy;
        model(NA, 1'b1);
        @(negedge clk); load_a = 1'b1; clr_a = 1'b1;
        @(negedge clk); load_a = 1'b0; clr_a = 1'b0; start_a = 1'b1;
        wait_done("held1", 1'b0);
        @(negedge clk);
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done("held2", 1'b0);
        repeat (3) @(negedge clk);
        chk("held done_pulses", done_n_a, 32'd2);
        chk("held busy_cycles", busy_n_a, 32'(2 * busy1));
        for (int i = 0; i < 16; i++) chk("held mem", mem_a[i], m_a[i]);
        repeat (5) @(negedge clk);
        chk("held no_requeue", 32'(busy_a), 32'd0);
        chk("held done_final", done_n_a, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
